riscv_seq_shifter: RTL and testbench

//   Multi-cycle shift unit for the RISC-V ALU. Applies one power-of-two shift stage per

---
 rtl/riscv_seq_shifter_if.sv | 26 ++
 rtl/riscv_seq_shifter.sv | 131 +++++++++++++
 tb/tb_riscv_seq_shifter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_seq_shifter_if.sv
// Valid/ready request and result channels of the sequential shifter.
// The master drives requests and accepts results; the slave is the shift unit.
interface riscv_seq_shifter_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_type;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, in_shamt, in_type, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_type, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/riscv_seq_shifter.sv
// Multi-cycle RV32 shifter: one power-of-two stage (16,8,4,2,1) per clock on a latched
// operand, fixed latency regardless of shift amount or type.
module riscv_seq_shifter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_seq_shifter_if.slave   bus
);

  localparam int unsigned      CNT_W      = $clog2(SHAMT_W + 1);
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W);
  localparam logic [SHAMT_W-1:0] FIRST_STEP = SHAMT_W'(1) << (SHAMT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  op_t                op_q, op_d;
  logic [CNT_W-1:0]   stage_q, stage_d;
  logic [SHAMT_W-1:0] step_q, step_d;
  logic [XLEN-1:0]    out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic [XLEN-1:0]    stage_data_c;

  // One shift stage: shamt_q is consumed MSB-first, so its top bit gates the current step.
  always_comb begin
    stage_data_c = data_q;
    if (shamt_q[SHAMT_W-1]) begin
      case (op_q)
        OP_SLL:  stage_data_c = data_q << step_q;
        OP_SRL:  stage_data_c = data_q >> step_q;
        OP_SRA:  stage_data_c = $unsigned($signed(data_q) >>> step_q);
        default: stage_data_c = data_q;
      endcase
    end
  end

  // Next-state and next-output logic; status outputs follow the next state.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    shamt_d    = shamt_q;
    op_d       = op_q;
    stage_d    = stage_q;
    step_d     = step_q;
    out_data_d = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          shamt_d = bus.in_shamt;
          op_d    = op_t'(bus.in_type);
          stage_d = '0;
          step_d  = FIRST_STEP;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (stage_q == LAST_STAGE) begin
          out_data_d = data_q;
          state_d    = ST_DONE;
        end else begin
          data_d  = stage_data_c;
          shamt_d = shamt_q << 1;
          step_d  = step_q >> 1;
          stage_d = stage_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      shamt_q     <= '0;
      op_q        <= OP_SLL;
      stage_q     <= '0;
      step_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      shamt_q     <= shamt_d;
      op_q        <= op_d;
      stage_q     <= stage_d;
      step_q      <= step_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_riscv_seq_shifter.sv
// Directed and randomised bench for riscv_seq_shifter: results, latency, backpressure,
// back-to-back traffic and mid-operation reset.
module tb_riscv_seq_shifter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  riscv_seq_shifter_if #(.XLEN(32), .SHAMT_W(5)) bus ();

  riscv_seq_shifter #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] t);
    case (t)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) chk({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Cycles from the accept edge until out_valid is seen, bounded.
  task automatic wait_result(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] t, input logic [31:0] exp);
    int lat;
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_type  = t;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_shamt = 5'($urandom);
    bus.in_type  = 2'($urandom);
    wait_result(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd6);
    chk({tag, "_data"}, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_vld_clr"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] hold;
    logic [31:0] rd;
    logic [4:0]  rs;
    logic [1:0]  rt;
    logic [31:0] b2b_d [6];
    logic [4:0]  b2b_s [6];
    logic [1:0]  b2b_t [6];

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_type   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    do_op("sll_1_31",     32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    do_op("sra_8000_4",   32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
    do_op("srl_8000_4",   32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
    do_op("sra_7fff_31",  32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000);
    do_op("sra_8000_31",  32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    do_op("srl_8000_31",  32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
    do_op("sll_0_dead",   32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
    do_op("srl_0_dead",   32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF);
    do_op("sra_0_dead",   32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);
    do_op("pass_0_dead",  32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF);
    do_op("pass_17_dead", 32'hDEAD_BEEF, 5'd17, 2'b11, 32'hDEAD_BEEF);
    do_op("sll_8",        32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800);
    do_op("srl_12",       32'hDEAD_BEEF, 5'd12, 2'b01, 32'h000D_EADB);
    do_op("sra_12",       32'hDEAD_BEEF, 5'd12, 2'b10, 32'hFFFD_EADB);

    // Backpressure: result held for three cycles, in_valid pulse ignored meanwhile.
    wait_ready("bp");
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hF0F0_F0F0;
    bus.in_shamt = 5'd4;
    bus.in_type  = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    chk("bp_lat", 32'(lat), 32'd6);
    hold = bus.out_data;
    chk("bp_data", hold, 32'h0F0F_0F0F);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stable", bus.out_data, 32'h0F0F_0F0F);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      bus.in_valid = (i == 1);
      bus.in_data  = 32'h1111_1111;
      bus.in_shamt = 5'd1;
      bus.in_type  = 2'b00;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_vld_clr", 32'(bus.out_valid), 32'd0);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    chk("bp_data_kept", bus.out_data, 32'h0F0F_0F0F);
    @(posedge clk); #1;
    chk("bp_no_accept", 32'(bus.busy), 32'd0);

    // Back-to-back with in_valid and out_ready held high.
    b2b_d = '{32'h0000_00FF, 32'h8765_4321, 32'hFFFF_0000, 32'h0F00_00F0, 32'h8000_0001, 32'hCAFE_F00D};
    b2b_s = '{5'd3, 5'd16, 5'd7, 5'd1, 5'd30, 5'd9};
    b2b_t = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wait_ready("b2b");
      bus.in_data  = b2b_d[r];
      bus.in_shamt = b2b_s[r];
      bus.in_type  = b2b_t[r];
      @(posedge clk); #1;
      bus.in_data  = ~b2b_d[r];
      bus.in_shamt = ~b2b_s[r];
      wait_result(lat);
      chk("b2b_lat", 32'(lat), 32'd6);
      chk("b2b_data", bus.out_data, ref_shift(b2b_d[r], b2b_s[r], b2b_t[r]));
      @(posedge clk); #1;
      chk("b2b_vld_clr", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset three cycles into SHIFT discards the operation.
    wait_ready("rst");
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A5_A5A5;
    bus.in_shamt = 5'd2;
    bus.in_type  = 2'b00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_stale", 32'(seen), 32'd0);
    do_op("post_rst", 32'h0000_0003, 5'd1, 2'b00, 32'h0000_0006);

    // Random operands against the reference model.
    for (int i = 0; i < 1500; i++) begin
      rd = $urandom;
      rs = 5'($urandom);
      rt = 2'($urandom);
      do_op("rand", rd, rs, rt, ref_shift(rd, rs, rt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
